// File: rtl/mac_chunk_accum_if.sv
// Streaming MAC bus: word input handshake, key, and final-MAC output handshake.
interface mac_chunk_accum_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] key;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         mac_valid;
  logic [N-1:0] mac;
  logic         mac_ready;

  // Producer / consumer side driving the MAC engine
  modport master (
    output key, in_valid, in_data, in_last, mac_ready,
    input  in_ready, mac_valid, mac
  );

  // MAC engine side
  modport slave (
    input  key, in_valid, in_data, in_last, mac_ready,
    output in_ready, mac_valid, mac
  );
endinterface

// File: rtl/mac_chunk_accum.sv
// Chunked MAC front end: sums CHUNK_WORDS-word chunks mod 2^N, folds each
// keyed chunk sum into a running MAC, and presents the MAC after the last word.
// Optional build macro MAC_CHAIN_ROT_EN: chain step rotates the running MAC
// left by one before XOR, making chunk order significant.
module mac_chunk_accum #(
  parameter int unsigned N           = 8,
  parameter int unsigned CHUNK_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_chunk_accum_if.slave      bus
);

  localparam int unsigned CW = (CHUNK_WORDS > 1) ? $clog2(CHUNK_WORDS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CHUNK_WORDS - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FOLD  = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  chunk_sum_q, chunk_sum_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [N-1:0]  running_q, running_d;
  logic          last_seen_q, last_seen_d;
  logic          in_ready_q, in_ready_d;
  logic          mac_valid_q, mac_valid_d;
  logic [N-1:0]  mac_q, mac_d;

  // Chain one keyed chunk sum into the running MAC
  function automatic logic [N-1:0] chain(input logic [N-1:0] r, input logic [N-1:0] c);
`ifdef MAC_CHAIN_ROT_EN
    return {r[N-2:0], r[N-1]} ^ c;
`else
    return r ^ c;
`endif
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      chunk_sum_q <= '0;
      word_cnt_q  <= '0;
      running_q   <= '0;
      last_seen_q <= 1'b0;
      in_ready_q  <= 1'b1;
      mac_valid_q <= 1'b0;
      mac_q       <= '0;
    end else begin
      state_q     <= state_d;
      chunk_sum_q <= chunk_sum_d;
      word_cnt_q  <= word_cnt_d;
      running_q   <= running_d;
      last_seen_q <= last_seen_d;
      in_ready_q  <= in_ready_d;
      mac_valid_q <= mac_valid_d;
      mac_q       <= mac_d;
    end
  end

  // Next-state, datapath updates and registered-output precompute
  always_comb begin
    state_d     = state_q;
    chunk_sum_d = chunk_sum_q;
    word_cnt_d  = word_cnt_q;
    running_d   = running_q;
    last_seen_d = last_seen_q;

    unique case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          chunk_sum_d = chunk_sum_q + bus.in_data;
          word_cnt_d  = word_cnt_q + CW'(1);
          last_seen_d = bus.in_last;
          if ((word_cnt_q == CNT_MAX) || bus.in_last) begin
            state_d = FOLD;
          end
        end
      end
      FOLD: begin
        running_d   = chain(running_q, chunk_sum_q ^ bus.key);
        chunk_sum_d = '0;
        word_cnt_d  = '0;
        state_d     = last_seen_q ? DONE : ACCUM;
      end
      DONE: begin
        if (bus.mac_ready) begin
          running_d   = '0;
          last_seen_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Outputs are registered copies of what the next state presents
    in_ready_d  = (state_d == ACCUM);
    mac_valid_d = (state_d == DONE);
    mac_d       = (state_d == DONE) ? running_d : '0;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac       = mac_q;

endmodule
